// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
// Optional build macro: COUNTER_SAT_EN (saturating count instead of modulo wrap).
package counter_pkg;

   localparam logic        CNT_UP    = 1'b1;
   localparam logic        CNT_DN    = 1'b0;
   localparam int unsigned CNT_W_DEF = 5;

   // Limit a load value to the highest legal count; operates on 32 bits so any WIDTH up to 32 fits.
   function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/counter_next.sv
// Next-count generator: modulo step in the requested direction plus a boundary flag.
// The boundary compare is explicit, so non-power-of-two moduli never rely on overflow.
module counter_next
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_W_DEF
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] nxt,
   output logic             bnd
);

   // Boundary detect and wrapped next value for the current direction.
   always_comb begin
      bnd = 1'b0;
      nxt = cnt;
      if (up_dn == CNT_UP) begin
         bnd = (cnt == max_val);
         nxt = bnd ? '0 : cnt + WIDTH'(1);
      end else begin
         bnd = (cnt == '0);
         nxt = bnd ? max_val : cnt - WIDTH'(1);
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with load, terminal count, wrap pulse and compare match.
// Optional build macro: COUNTER_SAT_EN -- counting saturates at the boundaries,
// wrap is tied low and a registered sat output is added.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH   = CNT_W_DEF,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enab,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic [WIDTH-1:0] cmp_val,
   output logic [WIDTH-1:0] cnt_out,
   output logic             tc,
   output logic             wrap,
   output logic             cmp_hit
`ifdef COUNTER_SAT_EN
   ,
   output logic             sat
`endif
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] step_nxt;
   logic             step_bnd;
   logic [WIDTH-1:0] load_val;
   logic             cmp_hit_q;

   counter_next #(.WIDTH(WIDTH)) u_next (
      .cnt     (cnt_q),
      .up_dn   (up_dn),
      .max_val (MAX_VAL),
      .nxt     (step_nxt),
      .bnd     (step_bnd)
   );

   assign load_val = WIDTH'(clamp_to_max(32'(cnt_in), 32'(MAX_VAL)));

   // Terminal count: an enabled step is about to cross the boundary this edge.
   assign tc = enab & ~load & step_bnd;

   // Priority load > enable > hold; saturating build freezes at the boundary.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (enab) begin
`ifdef COUNTER_SAT_EN
         cnt_d = step_bnd ? cnt_q : step_nxt;
`else
         cnt_d = step_nxt;
`endif
      end
   end

   // Count register and compare match on the value being loaded into it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= RST_VAL;
         cmp_hit_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cmp_hit_q <= (cnt_d == cmp_val);
      end
   end

`ifdef COUNTER_SAT_EN
   logic sat_q;

   // Sat flags a cycle in which an enabled step was blocked at the boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= tc;
      end
   end

   assign wrap = 1'b0;
   assign sat  = sat_q;
`else
   logic wrap_q;

   // Wrap pulse follows the terminal count by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= tc;
      end
   end

   assign wrap = wrap_q;
`endif

   assign cnt_out = cnt_q;
   assign cmp_hit = cmp_hit_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter, WIDTH=5, MAX_VAL=23, RST_VAL=0.
module tb_mod_updown_counter;

   logic       clk;
   logic       rst;
   logic       load;
   logic       enab;
   logic       up_dn;
   logic [4:0] cnt_in;
   logic [4:0] cmp_val;
   logic [4:0] cnt_out;
   logic       tc;
   logic       wrap;
   logic       cmp_hit;
`ifdef COUNTER_SAT_EN
   logic       sat;
`endif

   int n_cmp;
   int n_err;

   mod_updown_counter #(.WIDTH(5), .MAX_VAL(5'd23), .RST_VAL(5'd0)) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .enab    (enab),
      .up_dn   (up_dn),
      .cnt_in  (cnt_in),
      .cmp_val (cmp_val),
      .cnt_out (cnt_out),
      .tc      (tc),
      .wrap    (wrap),
      .cmp_hit (cmp_hit)
`ifdef COUNTER_SAT_EN
      ,
      .sat     (sat)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       ld;
      logic       en;
      logic       ud;
      logic [4:0] cin;
      logic [4:0] cmpv;
      logic [4:0] e_cnt;
      logic       e_tc;
      logic       e_wrap;
      logic       e_cmp;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Drive inputs after the falling edge, check tc, then check registered outputs after the next rising edge.
   task automatic apply(input logic ld, input logic en, input logic ud, input logic [4:0] cin, input logic [4:0] cmpv);
      @(negedge clk);
      load    = ld;
      enab    = en;
      up_dn   = ud;
      cnt_in  = cin;
      cmp_val = cmpv;
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'h15, 5'd31, 5'd21, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'h1F, 5'd31, 5'd23, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'h0A, 5'd31, 5'd10, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd22, 5'd31, 5'd22, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd31, 5'd23, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd31, 5'd0,  1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd31, 5'd1,  1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd31, 5'd0,  1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd31, 5'd23, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd31, 5'd23, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd3,  5'd5,  5'd3,  1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd5,  5'd4,  1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd5,  5'd5,  1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd5,  5'd6,  1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 5'd9,  5'd9,  5'd9,  1'b0, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd9,  5'd8,  1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd8,  5'd8,  1'b0, 1'b0, 1'b1};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 5'd23, 5'd31, 5'd23, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 1'b1, 5'd0,  5'd31, 5'd0,  1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd31, 5'd23, 1'b1, 1'b1, 1'b0};

      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      load    = 1'b0;
      enab    = 1'b0;
      up_dn   = 1'b1;
      cnt_in  = 5'd0;
      cmp_val = 5'd31;

      // Reset state before any clock edge.
      #2;
      chk("rst_cnt", 0, 32'(cnt_out), 32'd0);
      chk("rst_wrap", 0, 32'(wrap), 32'd0);
      chk("rst_cmp", 0, 32'(cmp_hit), 32'd0);
      chk("rst_tc", 0, 32'(tc), 32'd0);

      @(negedge clk);
      rst = 1'b1;

      // Load 7 with a matching compare, then assert reset asynchronously mid-cycle.
      apply(1'b1, 1'b0, 1'b1, 5'd7, 5'd7);
      after_edge();
      chk("pre_cnt", 0, 32'(cnt_out), 32'd7);
      chk("pre_cmp", 0, 32'(cmp_hit), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_cnt", 0, 32'(cnt_out), 32'd0);
      chk("async_wrap", 0, 32'(wrap), 32'd0);
      chk("async_cmp", 0, 32'(cmp_hit), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      apply(1'b1, 1'b0, 1'b0, 5'h15, 5'd31);
      after_edge();
      chk("rel_load", 0, 32'(cnt_out), 32'd21);

`ifndef COUNTER_SAT_EN
      for (int i = 0; i < 20; i++) begin
         apply(vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].cin, vecs[i].cmpv);
         chk("tc", i, 32'(tc), 32'(vecs[i].e_tc));
         after_edge();
         chk("cnt", i, 32'(cnt_out), 32'(vecs[i].e_cnt));
         chk("wrap", i, 32'(wrap), 32'(vecs[i].e_wrap));
         chk("cmp_hit", i, 32'(cmp_hit), 32'(vecs[i].e_cmp));
      end
`else
      // Saturating build: up from 22 sticks at 23, then steps down on direction change.
      apply(1'b1, 1'b0, 1'b1, 5'd22, 5'd31);
      after_edge();
      chk("sat_load", 0, 32'(cnt_out), 32'd22);
      apply(1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
      after_edge();
      chk("sat_cnt", 1, 32'(cnt_out), 32'd23);
      chk("sat_flag", 1, 32'(sat), 32'd0);
      for (int i = 2; i < 4; i++) begin
         apply(1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
         chk("sat_tc", i, 32'(tc), 32'd1);
         after_edge();
         chk("sat_cnt", i, 32'(cnt_out), 32'd23);
         chk("sat_flag", i, 32'(sat), 32'd1);
         chk("sat_wrap", i, 32'(wrap), 32'd0);
      end
      apply(1'b0, 1'b1, 1'b0, 5'd0, 5'd31);
      after_edge();
      chk("sat_cnt", 4, 32'(cnt_out), 32'd22);
      chk("sat_flag", 4, 32'(sat), 32'd0);
`endif

      // Reset and load together: reset wins.
      @(negedge clk);
      rst    = 1'b0;
      load   = 1'b1;
      enab   = 1'b1;
      cnt_in = 5'd12;
      after_edge();
      chk("rst_vs_load_cnt", 0, 32'(cnt_out), 32'd0);
      chk("rst_vs_load_wrap", 0, 32'(wrap), 32'd0);
      @(negedge clk);
      rst  = 1'b1;
      load = 1'b0;
      enab = 1'b0;
      after_edge();
      chk("post_rst_hold", 0, 32'(cnt_out), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
